// File: rtl/mem_stage_lsu_pkg.sv
// Shared definitions for the memory-stage load/store unit: access size codes,
// FSM state encoding, byte-enable constants and the alignment helper.
package mem_stage_lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [3:0] BE_NONE    = 4'b0000;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;
    localparam logic [3:0] BE_LO_HALF = 4'b0011;
    localparam logic [3:0] BE_HI_HALF = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    // Unknown size codes behave as word accesses, so they need word alignment.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
        logic mis;
        case (funct3)
            F3_B, F3_BU: mis = 1'b0;
            F3_H, F3_HU: mis = offset[0];
            default:     mis = (offset != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_stage_lsu_align.sv
// Lane steering for one side of the LSU: store side replicates data and builds
// byte enables, load side extracts the addressed lane and sign/zero-extends it.
module lsu_align
    import mem_stage_lsu_pkg::*;
#(
    parameter bit IS_LOAD = 1'b0
) (
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] data_in,
    output logic [3:0]  be,
    output logic [31:0] data_out
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Pick the active byte/halfword: addressed lane on loads, low bits on stores
    always_comb begin
        byte_s = data_in[7:0];
        half_s = data_in[15:0];
        if (IS_LOAD) begin
            case (offset)
                2'd0:    byte_s = data_in[7:0];
                2'd1:    byte_s = data_in[15:8];
                2'd2:    byte_s = data_in[23:16];
                2'd3:    byte_s = data_in[31:24];
                default: byte_s = data_in[7:0];
            endcase
            half_s = offset[1] ? data_in[31:16] : data_in[15:0];
        end else begin
            byte_s = data_in[7:0];
            half_s = data_in[15:0];
        end
    end

    // Size decode; funct3[2] marks the unsigned load variants
    always_comb begin
        be       = BE_WORD;
        data_out = data_in;
        case (funct3)
            F3_B, F3_BU: begin
                be = BE_BYTE0 << offset;
                if (IS_LOAD) begin
                    data_out = {{24{byte_s[7] & ~funct3[2]}}, byte_s};
                end else begin
                    data_out = {4{byte_s}};
                end
            end
            F3_H, F3_HU: begin
                be = offset[1] ? BE_HI_HALF : BE_LO_HALF;
                if (IS_LOAD) begin
                    data_out = {{16{half_s[15] & ~funct3[2]}}, half_s};
                end else begin
                    data_out = {2{half_s}};
                end
            end
            default: begin
                be       = BE_WORD;
                data_out = data_in;
            end
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: drives a req/ready data memory, stalls the pipe
// until the access ends. Optional feature macro: MISALIGN_CHECK_EN.
module mem_stage_lsu
    import mem_stage_lsu_pkg::*;
#(
    parameter int WAIT_LIMIT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read_m,
    input  logic        mem_write_m,
    input  logic [2:0]  funct3_m,
    input  logic [31:0] alu_result_m,
    input  logic [31:0] write_data_m,
    output logic        stall_m,
    output logic [31:0] read_data_m,
    output logic        bus_err_m,
    output logic        misalign_m,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata
);

    localparam int            CW       = $clog2(WAIT_LIMIT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_LIMIT - 1);

    logic [1:0]    state_r;
    logic [CW-1:0] cnt_r;
    logic [2:0]    funct3_r;
    logic [1:0]    offset_r;
    logic          dmem_req_r;
    logic          dmem_we_r;
    logic [31:0]   dmem_addr_r;
    logic [3:0]    dmem_be_r;
    logic [31:0]   dmem_wdata_r;
    logic [31:0]   read_data_r;
    logic          bus_err_r;
    logic          misalign_r;

    logic          access_s;
    logic          misalign_s;
    logic [3:0]    store_be_s;
    logic [31:0]   store_data_s;
    logic [3:0]    load_be_unused_s;
    logic [31:0]   load_data_s;

    assign access_s = mem_read_m | mem_write_m;

`ifdef MISALIGN_CHECK_EN
    assign misalign_s = is_misaligned(funct3_m, alu_result_m[1:0]);
`else
    assign misalign_s = 1'b0;
`endif

    lsu_align #(.IS_LOAD(1'b0)) u_store_align (
        .funct3   (funct3_m),
        .offset   (alu_result_m[1:0]),
        .data_in  (write_data_m),
        .be       (store_be_s),
        .data_out (store_data_s)
    );

    lsu_align #(.IS_LOAD(1'b1)) u_load_align (
        .funct3   (funct3_r),
        .offset   (offset_r),
        .data_in  (dmem_rdata),
        .be       (load_be_unused_s),
        .data_out (load_data_s)
    );

    // Hold the pipe while an access is pending or in flight; DONE releases it
    assign stall_m = ((state_r == ST_IDLE) && access_s) || (state_r == ST_REQ);

    assign dmem_req    = dmem_req_r;
    assign dmem_we     = dmem_we_r;
    assign dmem_addr   = dmem_addr_r;
    assign dmem_be     = dmem_be_r;
    assign dmem_wdata  = dmem_wdata_r;
    assign read_data_m = read_data_r;
    assign bus_err_m   = bus_err_r;
    assign misalign_m  = misalign_r;

    // Access FSM, wait counter and registered memory/pipeline outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            cnt_r        <= '0;
            funct3_r     <= 3'b000;
            offset_r     <= 2'b00;
            dmem_req_r   <= 1'b0;
            dmem_we_r    <= 1'b0;
            dmem_addr_r  <= 32'h0000_0000;
            dmem_be_r    <= BE_NONE;
            dmem_wdata_r <= 32'h0000_0000;
            read_data_r  <= 32'h0000_0000;
            bus_err_r    <= 1'b0;
            misalign_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    cnt_r       <= '0;
                    read_data_r <= 32'h0000_0000;
                    bus_err_r   <= 1'b0;
                    misalign_r  <= 1'b0;
                    if (access_s) begin
                        funct3_r     <= funct3_m;
                        offset_r     <= alu_result_m[1:0];
                        dmem_we_r    <= mem_write_m;
                        dmem_addr_r  <= {alu_result_m[31:2], 2'b00};
                        dmem_be_r    <= store_be_s;
                        dmem_wdata_r <= store_data_s;
                        if (misalign_s) begin
                            misalign_r <= 1'b1;
                            state_r    <= ST_DONE;
                        end else begin
                            dmem_req_r <= 1'b1;
                            state_r    <= ST_REQ;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (dmem_ready) begin
                        dmem_req_r  <= 1'b0;
                        read_data_r <= dmem_we_r ? 32'h0000_0000 : load_data_s;
                        state_r     <= ST_DONE;
                    end else if (cnt_r == CNT_LAST) begin
                        dmem_req_r  <= 1'b0;
                        read_data_r <= 32'h0000_0000;
                        bus_err_r   <= 1'b1;
                        state_r     <= ST_DONE;
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                ST_DONE: begin
                    read_data_r <= 32'h0000_0000;
                    bus_err_r   <= 1'b0;
                    misalign_r  <= 1'b0;
                    state_r     <= ST_IDLE;
                end
                default: begin
                    dmem_req_r <= 1'b0;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu: a driver pushes expected responses, a
// monitor pops them when the DONE cycle appears; a small memory model answers.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_read_m = 1'b0;
    logic        mem_write_m = 1'b0;
    logic [2:0]  funct3_m = 3'b000;
    logic [31:0] alu_result_m = 32'h0;
    logic [31:0] write_data_m = 32'h0;
    logic        stall_m;
    logic [31:0] read_data_m;
    logic        bus_err_m;
    logic        misalign_m;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ready = 1'b0;
    logic [31:0] dmem_rdata = 32'h0;

    mem_stage_lsu #(.WAIT_LIMIT(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_read_m   (mem_read_m),
        .mem_write_m  (mem_write_m),
        .funct3_m     (funct3_m),
        .alu_result_m (alu_result_m),
        .write_data_m (write_data_m),
        .stall_m      (stall_m),
        .read_data_m  (read_data_m),
        .bus_err_m    (bus_err_m),
        .misalign_m   (misalign_m),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_be      (dmem_be),
        .dmem_wdata   (dmem_wdata),
        .dmem_ready   (dmem_ready),
        .dmem_rdata   (dmem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        berr;
        logic        mis;
        int          stalls;
        logic        has_req;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    failures = 0;

    int          rsp_wait = 0;
    logic [31:0] rsp_data = 32'h0;
    logic        resp_en = 1'b1;
    logic        man_ready = 1'b0;
    int          req_n = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp_v);
        end
    endtask

    // Memory model: assert ready once rsp_wait REQ cycles have gone unanswered
    always @(negedge clk) begin
        logic auto_rdy;
        auto_rdy = 1'b0;
        if (dmem_req) begin
            req_n = req_n + 1;
            auto_rdy = (rsp_wait >= 0) && (req_n > rsp_wait);
        end else begin
            req_n = 0;
        end
        dmem_ready = resp_en ? auto_rdy : man_ready;
        dmem_rdata = rsp_data;
    end

    int          stall_cnt = 0;
    logic        got_req = 1'b0;
    logic        post_chk = 1'b0;
    logic        cap_we;
    logic [31:0] cap_addr;
    logic [3:0]  cap_be;
    logic [31:0] cap_wdata;
    exp_t        mon_e;
    string       mon_nm;

    // Monitor: count stall cycles, capture the request, score the DONE cycle
    always @(negedge clk) begin
        if (!rst) begin
            stall_cnt = 0;
            got_req   = 1'b0;
            post_chk  = 1'b0;
        end else begin
            if (post_chk) begin
                chk({mon_nm, ".bus_err_after"}, 32'(bus_err_m), 32'h0);
                chk({mon_nm, ".misalign_after"}, 32'(misalign_m), 32'h0);
                post_chk = 1'b0;
            end
            if (dmem_req && !got_req) begin
                got_req   = 1'b1;
                cap_we    = dmem_we;
                cap_addr  = dmem_addr;
                cap_be    = dmem_be;
                cap_wdata = dmem_wdata;
            end
            if (stall_m) begin
                stall_cnt++;
            end else if (stall_cnt > 0) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done actual=1 required=0");
                    mon_nm = "unexpected";
                end else begin
                    mon_e  = exp_q.pop_front();
                    mon_nm = name_q.pop_front();
                    chk({mon_nm, ".read_data"}, read_data_m, mon_e.rdata);
                    chk({mon_nm, ".bus_err"}, 32'(bus_err_m), 32'(mon_e.berr));
                    chk({mon_nm, ".misalign"}, 32'(misalign_m), 32'(mon_e.mis));
                    chk({mon_nm, ".stalls"}, 32'(stall_cnt), 32'(mon_e.stalls));
                    chk({mon_nm, ".req_seen"}, 32'(got_req), 32'(mon_e.has_req));
                    if (mon_e.has_req && got_req) begin
                        chk({mon_nm, ".addr"}, cap_addr, mon_e.addr);
                        chk({mon_nm, ".we"}, 32'(cap_we), 32'(mon_e.we));
                        if (mon_e.we) begin
                            chk({mon_nm, ".be"}, 32'(cap_be), 32'(mon_e.be));
                            chk({mon_nm, ".wdata"}, cap_wdata, mon_e.wdata);
                        end
                    end
                end
                stall_cnt = 0;
                got_req   = 1'b0;
                post_chk  = 1'b1;
            end
        end
    end

    task automatic run_access(input string nm, input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdw,
                              input int waitc, input logic [31:0] e_rdata, input logic e_berr,
                              input logic e_mis, input int e_stalls, input logic [3:0] e_be,
                              input logic [31:0] e_wdata);
        exp_t e;
        bit   done;
        e.rdata   = e_rdata;
        e.berr    = e_berr;
        e.mis     = e_mis;
        e.stalls  = e_stalls;
        e.has_req = !e_mis;
        e.we      = wr;
        e.addr    = {addr[31:2], 2'b00};
        e.be      = e_be;
        e.wdata   = e_wdata;
        exp_q.push_back(e);
        name_q.push_back(nm);
        rsp_wait     = waitc;
        rsp_data     = rdw;
        mem_read_m   = rd;
        mem_write_m  = wr;
        funct3_m     = f3;
        alu_result_m = addr;
        write_data_m = wd;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (!stall_m) done = 1'b1;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL %s.timeout actual=stalled required=done_within_40", nm);
        end
        @(posedge clk);
        #1;
        mem_read_m  = 1'b0;
        mem_write_m = 1'b0;
    endtask

    initial begin
        bit seen;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.stall", 32'(stall_m), 32'h0);
        chk("reset.dmem_req", 32'(dmem_req), 32'h0);
        chk("reset.read_data", read_data_m, 32'h0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        run_access("sw_word",     1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0,        0,
                   32'h0,        1'b0, 1'b0, 2, 4'b1111, 32'hDEADBEEF);
        run_access("sb_lane3",    1'b0, 1'b1, 3'b000, 32'h103, 32'h000000A5, 32'h0,        0,
                   32'h0,        1'b0, 1'b0, 2, 4'b1000, 32'hA5A5A5A5);
        run_access("lb_lane3",    1'b1, 1'b0, 3'b000, 32'h103, 32'h0,        32'h80000000, 0,
                   32'hFFFFFF80, 1'b0, 1'b0, 2, 4'b0000, 32'h0);
        run_access("lbu_lane3",   1'b1, 1'b0, 3'b100, 32'h103, 32'h0,        32'h80000000, 0,
                   32'h00000080, 1'b0, 1'b0, 2, 4'b0000, 32'h0);
        run_access("lh_hi_wait3", 1'b1, 1'b0, 3'b001, 32'h102, 32'h0,        32'h80011234, 3,
                   32'hFFFF8001, 1'b0, 1'b0, 5, 4'b0000, 32'h0);
        run_access("lhu_lo_wait1",1'b1, 1'b0, 3'b101, 32'h100, 32'h0,        32'h80011234, 1,
                   32'h00001234, 1'b0, 1'b0, 3, 4'b0000, 32'h0);
        run_access("sh_hi",       1'b0, 1'b1, 3'b001, 32'h102, 32'h0000BEEF, 32'h0,        0,
                   32'h0,        1'b0, 1'b0, 2, 4'b1100, 32'hBEEFBEEF);
        run_access("lb_lane1_pos",1'b1, 1'b0, 3'b000, 32'h101, 32'h0,        32'h00007F00, 0,
                   32'h0000007F, 1'b0, 1'b0, 2, 4'b0000, 32'h0);
        run_access("lw_timeout",  1'b1, 1'b0, 3'b010, 32'h108, 32'h0,        32'h55555555, -1,
                   32'h0,        1'b1, 1'b0, 5, 4'b0000, 32'h0);
`ifdef MISALIGN_CHECK_EN
        run_access("lw_misalign", 1'b1, 1'b0, 3'b010, 32'h101, 32'h0,        32'hCAFEF00D, 0,
                   32'h0,        1'b0, 1'b1, 1, 4'b0000, 32'h0);
`else
        run_access("lw_unaligned",1'b1, 1'b0, 3'b010, 32'h101, 32'h0,        32'hCAFEF00D, 0,
                   32'hCAFEF00D, 1'b0, 1'b0, 2, 4'b0000, 32'h0);
`endif

        // Reset in the middle of a request, then a late ready that must be ignored
        resp_en      = 1'b0;
        man_ready    = 1'b0;
        mem_read_m   = 1'b1;
        funct3_m     = 3'b010;
        alu_result_m = 32'h200;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (dmem_req) seen = 1'b1;
        end
        chk("abort.req_reached", 32'(seen), 32'h1);
        @(posedge clk);
        #1;
        rst        = 1'b0;
        mem_read_m = 1'b0;
        #1;
        chk("abort.stall", 32'(stall_m), 32'h0);
        chk("abort.dmem_req", 32'(dmem_req), 32'h0);
        chk("abort.dmem_we", 32'(dmem_we), 32'h0);
        chk("abort.dmem_addr", dmem_addr, 32'h0);
        chk("abort.dmem_be", 32'(dmem_be), 32'h0);
        chk("abort.dmem_wdata", dmem_wdata, 32'h0);
        chk("abort.read_data", read_data_m, 32'h0);
        chk("abort.bus_err", 32'(bus_err_m), 32'h0);
        chk("abort.misalign", 32'(misalign_m), 32'h0);
        @(posedge clk);
        #1;
        rst       = 1'b1;
        man_ready = 1'b1;
        rsp_data  = 32'hFFFFFFFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("late_ready.dmem_req", 32'(dmem_req), 32'h0);
            chk("late_ready.stall", 32'(stall_m), 32'h0);
            chk("late_ready.read_data", read_data_m, 32'h0);
        end
        man_ready = 1'b0;
        resp_en   = 1'b1;
        @(posedge clk);
        #1;
        run_access("lw_recover",  1'b1, 1'b0, 3'b010, 32'h104, 32'h0,        32'h12345678, 0,
                   32'h12345678, 1'b0, 1'b0, 2, 4'b0000, 32'h0);

        repeat (3) @(posedge clk);
        chk("scoreboard.drained", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_stage_lsu.md
# mem_stage_lsu

Memory-stage load/store unit for the pipelined RISC-V core. It consumes the EX/MEM pipeline register outputs (ALU result as address, store data, rd-independent control) and acts as the initiator toward a multi-cycle data memory over a req/ready handshake. It formats byte/halfword/word lanes, stalls the pipeline until the access completes, and presents load data to the MEM/WB register.

## Interface
- WAIT_LIMIT, 16: max cycles `dmem_req` is held without `dmem_ready` before timeout (≥1).

- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-low reset
- mem_read_m  in  1  load in MEM stage
- mem_write_m  in  1  store in MEM stage (wins if both asserted)
- funct3_m  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU; others treated as W
- alu_result_m  in  32  byte address
- write_data_m  in  32  store data (low bits used for B/H)
- stall_m  out  1  hold IF/ID/EX/MEM registers this cycle
- read_data_m  out  32  formatted load data, valid in DONE
- bus_err_m  out  1  one-cycle pulse in DONE on timeout
- misalign_m  out  1  one-cycle pulse in DONE on misaligned access (macro only; tied 0 otherwise)
- dmem_req  out  1  request valid
- dmem_we  out  1  1 = write
- dmem_addr  out  32  word address ({alu_result_m[31:2],2'b00})
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-replicated store data
- dmem_ready  in  1  memory accepted/completed request this cycle
- dmem_rdata  in  32  read word, valid when dmem_ready=1

## Operation
- FSM states IDLE, REQ, DONE.
- IDLE: no access -> stall_m=0, stay. Access present -> stall_m=1 (combinational), latch addr/be/wdata/we/funct3, next REQ; clear wait counter.
- REQ: dmem_req=1, stall_m=1, outputs stable from latches. dmem_ready=1 -> capture dmem_rdata (loads), next DONE. Counter reaches WAIT_LIMIT-1 without ready -> drop req, read data 0, set bus_err flag, next DONE.
- DONE: stall_m=0, dmem_req=0, read_data_m = formatted captured data, flags pulse; next IDLE unconditionally. Pipeline advances on this edge.
- Stores: SB be=1<<addr[1:0], wdata={4{byte}}; SH be=addr[1]?4'b1100:4'b0011, wdata={2{half}}; SW be=4'b1111.
- Loads: select lane by addr[1:0]/addr[1]; B/H sign-extend, BU/HU zero-extend; W passes through. read_data_m=0 for stores.
- Response with dmem_ready outside REQ is ignored.

## Timing
- Reset (rst=0): state IDLE, stall_m=0, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_be=0, dmem_wdata=0, read_data_m=0, bus_err_m=0, misalign_m=0, counter 0. Reset mid-REQ abandons the access; a late dmem_ready is ignored.
- Best case: ready in first REQ cycle -> 2 stall cycles (IDLE, REQ), DONE in cycle 3.
- Each extra REQ cycle adds one stall cycle; timeout after exactly WAIT_LIMIT REQ cycles.
- Back-to-back accesses: DONE always followed by IDLE; next access stalls from its IDLE cycle.
- dmem_* outputs registered; stall_m combinational from state and mem_read_m/mem_write_m.

## Configuration
- MISALIGN_CHECK_EN defined: H with addr[0]=1 or W with addr[1:0]≠0 -> IDLE goes straight to DONE, no dmem_req, read_data_m=0, misalign_m pulses in DONE (1 stall cycle).
- Undefined: no check; H uses addr[1] only, W ignores addr[1:0]; misalign_m tied 0.

## Structure
- Shared defs package: funct3 size codes (B/H/W/BU/HU), FSM state encoding, byte-enable constants.
- Sub-module lsu_align: combinational store lane/be generation and load extract/extend; instanced once for store side, once for load side.

## Test plan
- SW addr 0x100, data 0xDEADBEEF, ready on first REQ cycle -> dmem_addr 0x100, be 1111, wdata 0xDEADBEEF, stall 2 cycles.
- SB addr 0x103, data 0x000000A5 -> be 1000, wdata 0xA5A5A5A5; LB same addr, rdata 0x80000000 -> read_data_m 0xFFFFFF80; LBU -> 0x00000080.
- LH addr 0x102, rdata 0x8001_1234, ready after 3 wait cycles -> read_data_m 0xFFFF8001, stall 5 cycles.
- WAIT_LIMIT=4, ready never asserted -> req drops after 4 REQ cycles, bus_err_m=1 one cycle, read_data_m 0.
- rst low during REQ, then ready pulses -> all outputs 0, state IDLE, late ready ignored.
- MISALIGN_CHECK_EN, LW addr 0x101 -> no dmem_req, misalign_m=1 in DONE, stall 1 cycle.
